// File: rtl/bitty_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO on the bitty data bus.
// Registers: TXDATA (push), STATUS, BAUDDIV; frames are serialised LSB first on txd.
module bitty_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        txd,
   output logic        tx_busy
);
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned DIV_W = 16;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

   state_e             state_q, state_d;
   logic [7:0]         shift_q, shift_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [DIV_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   reload_q, reload_d;
   logic [DIV_W-1:0]   baud_q, baud_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         mem_q [DEPTH];
   logic [7:0]         mem_d [DEPTH];
   logic               txd_q, txd_d;
   logic               tx_busy_q, tx_busy_d;

   logic               hit, empty, full, pop, push, push_ok, ovf_clr;
   logic [1:0]         reg_sel;
   logic               unused_bits;

   assign unused_bits = ^{addr[1:0], data_i[31:16]};

   // Bus decode
   assign hit     = ce && (addr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel = addr[3:2];
   assign empty   = (count_q == CNT_W'(0));
   assign full    = (count_q == CNT_W'(DEPTH));
   assign push    = hit && we && sel[0] && (reg_sel == 2'd0);
   assign ovf_clr = hit && we && sel[0] && (reg_sel == 2'd1) && data_i[3];

   // Transmit FSM; txd is registered from the next-state view so it changes with the state
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      bit_cnt_d = bit_cnt_q;
      reload_d  = reload_q;
      pop       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = mem_q[rptr_q];
               reload_d  = baud_q;
               bit_cnt_d = baud_q;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_cnt_q == DIV_W'(0)) begin
               state_d   = ST_DATA;
               bit_idx_d = IDX_W'(0);
               bit_cnt_d = reload_q;
            end else begin
               bit_cnt_d = bit_cnt_q - DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_cnt_q == DIV_W'(0)) begin
               bit_cnt_d = reload_q;
               shift_d   = shift_q >> 1;
               if (bit_idx_q == IDX_W'(7)) state_d = ST_STOP;
               else bit_idx_d = bit_idx_q + IDX_W'(1);
            end else begin
               bit_cnt_d = bit_cnt_q - DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_cnt_q == DIV_W'(0)) begin
               if (!empty) begin
                  pop       = 1'b1;
                  shift_d   = mem_q[rptr_q];
                  reload_d  = baud_q;
                  bit_cnt_d = baud_q;
                  state_d   = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // FIFO, overflow flag and baud divisor
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      baud_d  = baud_q;
      push_ok = push && (!full || pop);
      if (push_ok) begin
         mem_d[wptr_q] = data_i[7:0];
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
      if (push && full && !pop) ovf_d = 1'b1;
      else if (ovf_clr)         ovf_d = 1'b0;
      if (hit && we && (reg_sel == 2'd2)) begin
         if (sel[0]) baud_d[7:0]  = data_i[7:0];
         if (sel[1]) baud_d[15:8] = data_i[15:8];
      end
   end

   assign tx_busy_d = (state_d != ST_IDLE) || (count_d != CNT_W'(0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         bit_cnt_q <= '0;
         reload_q  <= '0;
         baud_q    <= DEFAULT_DIV;
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         txd_q     <= 1'b1;
         tx_busy_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         bit_cnt_q <= bit_cnt_d;
         reload_q  <= reload_d;
         baud_q    <= baud_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         txd_q     <= txd_d;
         tx_busy_q <= tx_busy_d;
         mem_q     <= mem_d;
      end
   end

   assign txd     = txd_q;
   assign tx_busy = tx_busy_q;

   // Read mux: combinational, zero unless this is a read hit
   always_comb begin
      data_o = 32'd0;
      if (hit && !we) begin
         unique case (reg_sel)
            2'd1:    data_o = {25'd0, count_q, ovf_q, empty, full, tx_busy_q};
            2'd2:    data_o = {16'd0, baud_q};
            default: data_o = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_bitty_uart_tx.sv
// Self-checking bench for bitty_uart_tx: txd is logged every cycle and compared
// against an ideal waveform computed from a list of queued bytes and divisors.
module tb_bitty_uart_tx;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, data_i = '0;
   logic [3:0]  sel = '0;
   logic [31:0] data_o;
   logic        txd, tx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic txd_log[$];
   logic busy_log[$];
   bit   logging = 1'b0;

   // Reference frame list: bytes sent back to back starting at log index m_start
   logic [7:0] m_bytes[$];
   int         m_divs[$];
   int         m_start;

   bitty_uart_tx dut (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .data_o(data_o), .txd(txd), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (logging) begin
         txd_log.push_back(txd);
         busy_log.push_back(tx_busy);
      end
   end

   function automatic logic exp_txd(int idx);
      int t;
      t = idx - m_start;
      if (t < 0) return 1'b1;
      foreach (m_bytes[k]) begin
         int per, len, b;
         per = m_divs[k] + 1;
         len = 10 * per;
         if (t < len) begin
            b = t / per;
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return m_bytes[k][b-1];
         end
         t -= len;
      end
      return 1'b1;
   endfunction

   task automatic put(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d;
   endtask

   task automatic release_bus();
      @(negedge clk);
      ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
      #1 v = data_o;
      #1 ce = 1'b0; addr = '0; sel = '0;
   endtask

   task automatic start_log();
      txd_log.delete();
      busy_log.delete();
      logging = 1'b1;
   endtask

   task automatic stop_log(input int cycles);
      repeat (cycles) @(posedge clk);
      #3 logging = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      n_tests++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h4) begin n_fail++; $display("FAIL reset_status got %h want 00000004", v); end
      rd(BASE + 32'h8, v);
      n_tests++;
      if (v !== 32'd433) begin n_fail++; $display("FAIL reset_baud got %0d want 433", v); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] v;
      // Only the upper byte of the divisor changes; the reset low byte 0xB1 stays
      put(BASE + 32'h8, 4'b0010, 32'h0000_ABCD);
      release_bus();
      rd(BASE + 32'h8, v);
      n_tests++;
      if (v !== 32'h0000_ABB1) begin n_fail++; $display("FAIL lane_baud got %h want 0000abb1", v); end
      put(BASE, 4'b0010, 32'h5A);
      release_bus();
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h4) begin n_fail++; $display("FAIL lane_nopush got %h want 00000004", v); end
   endtask

   task automatic test_single_byte();
      logic [7:0] vals[3];
      int bad;
      put(BASE + 32'h8, 4'b0011, 32'd3);
      release_bus();
      vals[0] = 8'h55;
      vals[1] = 8'($urandom);
      vals[2] = 8'($urandom);
      foreach (vals[j]) begin
         m_bytes = '{vals[j]}; m_divs = '{3}; m_start = 1;
         put(BASE, 4'b0001, {24'd0, vals[j]});
         start_log();
         release_bus();
         stop_log(50);
         bad = -1;
         for (int i = 0; i < 50; i++)
            if (bad < 0 && txd_log[i] !== exp_txd(i)) bad = i;
         n_tests++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL single_frame byte %h idx %0d got %b want %b", vals[j], bad, txd_log[bad], exp_txd(bad));
         end
         n_tests++;
         if (busy_log[0] !== 1'b1 || busy_log[40] !== 1'b1 || busy_log[41] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy byte %h got E:%b E+40:%b E+41:%b want 1 1 0", vals[j], busy_log[0], busy_log[40], busy_log[41]);
         end
      end
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] v;
      int bad;
      m_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      m_divs  = '{3, 3, 3, 3, 3};
      m_start = 1;
      for (int i = 1; i <= 6; i++) begin
         put(BASE, 4'b0001, 32'(i));
         if (i == 1) start_log();
      end
      release_bus();
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h4B) begin n_fail++; $display("FAIL fifo_status_full got %h want 0000004b", v); end
      stop_log(230);
      bad = -1;
      for (int i = 0; i < 230; i++)
         if (bad < 0 && txd_log[i] !== exp_txd(i)) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL fifo_frames idx %0d got %b want %b", bad, txd_log[bad], exp_txd(bad));
      end
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h0C) begin n_fail++; $display("FAIL fifo_status_drained got %h want 0000000c", v); end
      put(BASE + 32'h4, 4'b0001, 32'h8);
      release_bus();
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h04) begin n_fail++; $display("FAIL ovf_clear got %h want 00000004", v); end
   endtask

   task automatic test_random_bursts();
      int n, div, total, bad;
      for (int trial = 0; trial < 4; trial++) begin
         div = int'($urandom_range(0, 4));
         n   = int'($urandom_range(1, 5));
         put(BASE + 32'h8, 4'b0011, 32'(div));
         release_bus();
         m_bytes.delete(); m_divs.delete(); m_start = 1;
         for (int i = 0; i < n; i++) begin
            m_bytes.push_back(8'($urandom));
            m_divs.push_back(div);
         end
         for (int i = 0; i < n; i++) begin
            put(BASE, 4'b0001, {24'd0, m_bytes[i]});
            if (i == 0) start_log();
         end
         release_bus();
         total = n * 10 * (div + 1) + 10;
         stop_log(total);
         bad = -1;
         for (int i = 0; i < total; i++)
            if (bad < 0 && txd_log[i] !== exp_txd(i)) bad = i;
         n_tests++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL burst n=%0d div=%0d idx %0d got %b want %b", n, div, bad, txd_log[bad], exp_txd(bad));
         end
      end
   endtask

   task automatic test_baud_change();
      int bad;
      m_bytes = '{8'($urandom), 8'($urandom)};
      m_divs  = '{3, 7};
      m_start = 1;
      put(BASE + 32'h8, 4'b0011, 32'd3);
      release_bus();
      put(BASE, 4'b0001, {24'd0, m_bytes[0]});
      start_log();
      put(BASE, 4'b0001, {24'd0, m_bytes[1]});
      release_bus();
      repeat (10) @(posedge clk);
      put(BASE + 32'h8, 4'b0011, 32'd7);
      release_bus();
      wait (txd_log.size() >= 131);
      #3 logging = 1'b0;
      bad = -1;
      for (int i = 0; i < 131; i++)
         if (bad < 0 && txd_log[i] !== exp_txd(i)) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL baud_change idx %0d got %b want %b", bad, txd_log[bad], exp_txd(bad));
      end
   endtask

   task automatic test_decode();
      logic [31:0] v;
      put(BASE + 32'h10, 4'hF, 32'hFF);
      release_bus();
      rd(BASE + 32'h10, v);
      n_tests++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL decode_outside got %h want 0", v); end
      put(BASE + 32'hC, 4'hF, 32'hFFFF_FFFF);
      release_bus();
      rd(BASE + 32'hC, v);
      n_tests++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL decode_reserved got %h want 0", v); end
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h4 || txd !== 1'b1) begin
         n_fail++; $display("FAIL decode_status got %h txd %b want 00000004 txd 1", v, txd);
      end
      rd(BASE + 32'h8, v);
      n_tests++;
      if (v !== 32'd7) begin n_fail++; $display("FAIL decode_baud got %0d want 7", v); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v;
      int bad;
      put(BASE + 32'h8, 4'b0011, 32'd3);
      release_bus();
      put(BASE, 4'b0001, 32'h00);
      put(BASE, 4'b0001, 32'hFF);
      release_bus();
      repeat (8) @(posedge clk);
      #3;
      n_tests++;
      if (txd !== 1'b0) begin n_fail++; $display("FAIL midframe_data got %b want 0", txd); end
      rst = 1'b0;
      #1;
      n_tests++;
      if (txd !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got txd %b busy %b want 1 0", txd, tx_busy);
      end
      rd(BASE + 32'h4, v);
      n_tests++;
      if (v !== 32'h4) begin n_fail++; $display("FAIL reset_empty got %h want 00000004", v); end
      @(negedge clk) rst = 1'b1;
      start_log();
      stop_log(60);
      bad = -1;
      for (int i = 0; i < 60; i++)
         if (bad < 0 && (txd_log[i] !== 1'b1 || busy_log[i] !== 1'b0)) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++; $display("FAIL post_reset_idle idx %0d got txd %b busy %b want 1 0", bad, txd_log[bad], busy_log[bad]);
      end
      rd(BASE + 32'h8, v);
      n_tests++;
      if (v !== 32'd433) begin n_fail++; $display("FAIL post_reset_baud got %0d want 433", v); end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_single_byte();
      test_fifo_overflow();
      test_random_bursts();
      test_baud_change();
      test_decode();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
